ps2_scan_display: RTL and testbench
===================================

Name: ps2_scan_display

Overview:
- PS/2 keyboard front end: receives 11-bit PS/2 frames, validates them, and presents the current and previous scan-code bytes with a one-cycle ready strobe.
- Drives a two-digit hex 7-segment display of the latest byte.
- Counts received 0xF0 break prefixes (key releases) and drives a two-digit BCD 7-segment display of that count.
- Sits between the board PS/2 pins/segment LEDs and the top-level key-handling logic.

Parameters:
- SYNC_STAGES, 3, number of flops in the ps2_clk synchroniser (minimum 3).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock from the device (asynchronous).
- ps2_data  in  1  raw PS/2 data from the device.
- data  out  8  most recent valid scan byte.
- data_prev  out  8  valid scan byte received before data.
- ready  out  1  one-cycle strobe: data/data_prev updated this cycle.
- count  out  8  number of 0xF0 bytes received, modulo 256.
- hex_lo  out  7  segments for data[3:0], hex font.
- hex_hi  out  7  segments for data[7:4], hex font.
- cnt_lo  out  7  segments for count[3:0], BCD font.
- cnt_hi  out  7  segments for count[7:4], BCD font.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on clrn.
- Reset values:
  - data = data_prev = 0x00, ready = 0, count = 0x00.
  - Bit counter = 0 and frame buffer = 0.
  - Synchroniser flops are set to 1 (idle line).
  - hex_lo, hex_hi, cnt_lo, cnt_hi all read 7'b1111111 (blank).
- Segment format: bit order {g,f,e,d,c,b,a}, active-low (0 = lit). Encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- ps2_clk synchronisation: shift ps2_clk through SYNC_STAGES flops. A falling edge is detected when the oldest stage is 1 and the next stage is 0. ps2_data is sampled on that clk cycle.
- Frame reception:
  - On each detected falling edge while the bit counter is 0..9, store ps2_data at buffer[counter], then increment the counter.
  - The buffer layout is: bit 0 start, bits 1-8 data (LSB first), bit 9 parity.
  - On the edge with counter = 10 (stop bit), the frame is valid iff buffer[0] = 0, ps2_data = 1, and XOR of buffer[9:1] = 1 (odd parity).
  - Counter returns to 0 after the stop bit, whether or not the frame was valid.
- Valid frame, one clk later:
  - data_prev <= data; data <= buffer[8:1]; ready = 1 for exactly one cycle.
  - If the byte is 0xF0, count increments by 1 in the same cycle that ready is high. 0xFF wraps to 0x00.
- Invalid frame (bad start, stop or parity): byte dropped; data, data_prev, count and displays unchanged; no ready.
- No timeout: a partial frame stays pending until further edges arrive. Only reset clears it.
- Hex display:
  - Registers data on each ready pulse and decodes the registered value, so the display updates one cycle after ready.
  - Stays blank until the first valid byte after reset, then always shows both digits.
- BCD display: combinational from count, with no blanking-until-valid.
  - Nibble values 0-9 use the font above.
  - Nibble values 0xA-0xF output 1111111 (blank).
  - Blank after reset because count = 0 is held by the reset output rule.
- Reset asserted mid-frame discards the partial frame immediately. Reception restarts cleanly with the next start bit after release.

Test Plan:
- Reset, then idle lines high → data = 0x00, data_prev = 0x00, ready never asserts, all four segment outputs = 1111111.
- Send 0x1C (data LSB first, parity 0) → exactly one ready pulse; data = 0x1C; next cycle hex_hi = 1111001, hex_lo = 1000110; count = 0.
- Send 0x1C, then 0xF0 (parity 1) → data = 0xF0, data_prev = 0x1C, count = 1, cnt_lo = 1111001, cnt_hi = 1000000, hex_hi = hex_lo = 0001110.
- Send 0x1C with parity bit 1 (wrong), and separately a frame with stop bit 0 → no ready; data, data_prev and count unchanged.
- Send 10 × 0xF0 → count = 0x0A, cnt_lo = 1111111, cnt_hi = 1000000. Continue to 256 × 0xF0 → count wraps to 0x00.
- Pulse clrn low after 5 bits of a frame, then send a full 0x29 frame → only 0x29 is received; data = 0x29, data_prev = 0x00.

Source files
------------

// File: rtl/ps2_scan_display.sv
// PS/2 keyboard receiver with hex display of the latest scan byte and a
// BCD display of the number of 0xF0 break prefixes received.
module ps2_scan_display #(
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic [7:0] data_prev,
    output logic       ready,
    output logic [7:0] count,
    output logic [6:0] hex_lo,
    output logic [6:0] hex_hi,
    output logic [6:0] cnt_lo,
    output logic [6:0] cnt_hi
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] bcd_seg(input logic [3:0] nib);
        return (nib > 4'd9) ? SEG_BLANK : hex_seg(nib);
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   fall_p0;
    logic [3:0]             bit_cnt;
    logic [9:0]             frame_buf;
    logic                   frame_ok;
    logic [7:0]             hex_q_p1;
    logic                   hex_vld_p1;

    // Stage 0: ps2_clk synchroniser and falling-edge detect (oldest stage is MSB)
    assign fall_p0  = sync_p0[SYNC_STAGES-1] & ~sync_p0[SYNC_STAGES-2];
    assign frame_ok = (bit_cnt == 4'd10) && !frame_buf[0] && ps2_data && (^frame_buf[9:1]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_p0   <= '1;
            bit_cnt   <= 4'd0;
            frame_buf <= 10'd0;
            data      <= 8'h00;
            data_prev <= 8'h00;
            ready     <= 1'b0;
            count     <= 8'h00;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ps2_clk};
            ready   <= 1'b0;
            if (fall_p0) begin
                if (bit_cnt == 4'd10) begin
                    // Stop bit: accept or drop the frame, always rearm for the next start bit
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        data      <= frame_buf[8:1];
                        data_prev <= data;
                        ready     <= 1'b1;
                        if (frame_buf[8:1] == 8'hF0)
                            count <= count + 8'd1;
                    end
                end else begin
                    frame_buf[bit_cnt] <= ps2_data;
                    bit_cnt            <= bit_cnt + 4'd1;
                end
            end
        end
    end

    // Stage 1: display register, loaded on each accepted byte
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hex_q_p1   <= 8'h00;
            hex_vld_p1 <= 1'b0;
        end else if (ready) begin
            hex_q_p1   <= data;
            hex_vld_p1 <= 1'b1;
        end
    end

    assign hex_lo = hex_vld_p1 ? hex_seg(hex_q_p1[3:0]) : SEG_BLANK;
    assign hex_hi = hex_vld_p1 ? hex_seg(hex_q_p1[7:4]) : SEG_BLANK;

    // A zero count shows nothing, so the display is dark out of reset.
    assign cnt_lo = (count == 8'h00) ? SEG_BLANK : bcd_seg(count[3:0]);
    assign cnt_hi = (count == 8'h00) ? SEG_BLANK : bcd_seg(count[7:4]);

endmodule

// File: tb/tb_ps2_scan_display.sv
// Bench for ps2_scan_display: vector table of frames plus multi-frame
// sequences, with a queue of expected bytes checked on every ready pulse.
module tb_ps2_scan_display;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic [7:0] data_prev;
    logic       ready;
    logic [7:0] count;
    logic [6:0] hex_lo;
    logic [6:0] hex_hi;
    logic [6:0] cnt_lo;
    logic [6:0] cnt_hi;

    ps2_scan_display #(.SYNC_STAGES(3)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .data_prev (data_prev),
        .ready     (ready),
        .count     (count),
        .hex_lo    (hex_lo),
        .hex_hi    (hex_hi),
        .cnt_lo    (cnt_lo),
        .cnt_hi    (cnt_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] p;
        logic [7:0] c;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        logic [6:0] e_hi;
        logic [6:0] e_lo;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[10];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic [7:0] m_cnt  = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        logic        par;
        exp_t        e;
        par = ~(^b) ^ bad_par;
        f   = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && !bad_par && !bad_stop) begin
                m_cnt  = (b == 8'hF0) ? m_cnt + 8'd1 : m_cnt;
                e.d    = b;
                e.p    = m_data;
                e.c    = m_cnt;
                sb_q.push_back(e);
                m_prev = m_data;
                m_data = b;
            end
            ps2_data = f[i];
            repeat (3) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (5) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (3) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (clrn && ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", data, e.d);
                chk("sb_data_prev", data_prev, e.p);
                chk("sb_count", count, e.c);
            end
        end
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b0, 7'b1111001, 7'b1000110};
        vecs[1] = '{8'hF0, 1'b0, 1'b0, 7'b0001110, 7'b1000000};
        vecs[2] = '{8'h1C, 1'b1, 1'b0, 7'b0001110, 7'b1000000};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 7'b0001110, 7'b1000000};
        vecs[4] = '{8'h29, 1'b0, 1'b0, 7'b0100100, 7'b0010000};
        vecs[5] = '{8'hA5, 1'b0, 1'b0, 7'b0001000, 7'b0010010};
        vecs[6] = '{8'h3B, 1'b0, 1'b0, 7'b0110000, 7'b0000011};
        vecs[7] = '{8'hE7, 1'b0, 1'b0, 7'b0000110, 7'b1111000};
        vecs[8] = '{8'hD6, 1'b0, 1'b0, 7'b0100001, 7'b0000010};
        vecs[9] = '{8'h84, 1'b0, 1'b0, 7'b0000000, 7'b0011001};

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clrn     = 1'b0;
        repeat (3) @(posedge clk);
        clrn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_data_prev", data_prev, 8'h00);
        chk("rst_count", count, 8'h00);
        chk("rst_hex_lo", hex_lo, 7'b1111111);
        chk("rst_hex_hi", hex_hi, 7'b1111111);
        chk("rst_cnt_lo", cnt_lo, 7'b1111111);
        chk("rst_cnt_hi", cnt_hi, 7'b1111111);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, 11);
            #1;
            chk("vec_hex_hi", hex_hi, vecs[i].e_hi);
            chk("vec_hex_lo", hex_lo, vecs[i].e_lo);
            chk("vec_data", data, m_data);
            chk("vec_data_prev", data_prev, m_prev);
            chk("vec_count", count, m_cnt);
        end
        chk("one_break_cnt_lo", cnt_lo, 7'b1111001);
        chk("one_break_cnt_hi", cnt_hi, 7'b1000000);

        for (int i = 0; i < 9; i++) send_frame(8'hF0, 1'b0, 1'b0, 11);
        #1;
        chk("ten_count", count, 8'h0A);
        chk("ten_cnt_lo", cnt_lo, 7'b1111111);
        chk("ten_cnt_hi", cnt_hi, 7'b1000000);

        for (int i = 0; i < 15; i++) send_frame(8'hF0, 1'b0, 1'b0, 11);
        #1;
        chk("x19_count", count, 8'h19);
        chk("x19_cnt_lo", cnt_lo, 7'b0010000);
        chk("x19_cnt_hi", cnt_hi, 7'b1111001);

        for (int i = 0; i < 231; i++) send_frame(8'hF0, 1'b0, 1'b0, 11);
        #1;
        chk("wrap_count", count, 8'h00);
        chk("wrap_data", data, 8'hF0);
        chk("wrap_data_prev", data_prev, 8'hF0);

        send_frame(8'h5A, 1'b0, 1'b0, 5);
        #3;
        clrn = 1'b0;
        sb_q.delete();
        m_data = 8'h00;
        m_prev = 8'h00;
        m_cnt  = 8'h00;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_hex_hi", hex_hi, 7'b1111111);
        chk("midrst_ready", ready, 1'b0);
        repeat (2) @(posedge clk);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h29, 1'b0, 1'b0, 11);
        #1;
        chk("after_rst_data", data, 8'h29);
        chk("after_rst_data_prev", data_prev, 8'h00);
        chk("after_rst_count", count, 8'h00);
        chk("after_rst_hex_hi", hex_hi, 7'b0100100);
        chk("after_rst_hex_lo", hex_lo, 7'b0010000);

        repeat (10) @(posedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
